// File: rtl/sevga_pkg.sv
// Shared definitions for the Mac SE video pixel path: controller state
// encoding and line geometry constants.
package sevga_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    ACTIVE = 2'd2
  } shctl_state_t;

  localparam int PIX_PER_BYTE   = 8;
  localparam int LINE_BYTES_DEF = 64;
  localparam int ADDR_W_DEF     = 15;

endpackage

// File: rtl/byte_fifo2.sv
// Two-entry 8-bit prefetch FIFO with flush. Head is visible combinationally;
// a simultaneous push and pop keeps the count and advances the head.
module byte_fifo2 (
  input  logic       clk,
  input  logic       nReset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [1:0] count,
  output logic [7:0] head
);

  logic [7:0] mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic       do_push;
  logic       do_pop;

  // Pop only a non-empty FIFO; push into a full FIFO only when a pop frees a slot.
  always_comb begin
    do_pop  = pop && (count != 2'd0);
    do_push = push && ((count != 2'd2) || do_pop);
  end

  // Storage, pointers and occupancy; flush empties the FIFO and wins over push/pop.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      mem[0] <= 8'h00;
      mem[1] <= 8'h00;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/pixel_shift_ctrl.sv
// Scanline sequencer for the piso8 pixel shifter (1bpp Mac SE video).
// Fetches LINE_BYTES bytes over a req/ack port into a 2-entry prefetch FIFO
// and issues a shifter load every 8th enabled pixel.
// Optional build macro SEVGA_UNDERRUN_CNT_EN adds a saturating underrun counter.
//
// Fetch handshake: a byte moves in any cycle with fetchReq=1 and fetchAck=1.
// fetchAddr is stable while fetchReq waits for ack; fetchReq only drops
// without ack when the line is aborted (restart, reset, or line end).
module pixel_shift_ctrl
  import sevga_pkg::*;
#(
  parameter int LINE_BYTES = LINE_BYTES_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              lineStart,
  input  logic [ADDR_W-1:0] lineBase,
  input  logic              pixEn,
  output logic              fetchReq,
  output logic [ADDR_W-1:0] fetchAddr,
  input  logic              fetchAck,
  input  logic [7:0]        fetchData,
  output logic              shLoad,
  output logic [7:0]        shData,
  output logic              active,
  output logic              lineDone,
  output logic              underrun,
`ifdef SEVGA_UNDERRUN_CNT_EN
  output logic [7:0]        underrunCnt,
`endif
  input  logic              clrErr,
  output shctl_state_t      dbg_state
);

  localparam logic [7:0] LB = 8'(LINE_BYTES);

  shctl_state_t      state;
  shctl_state_t      state_n;
  logic [ADDR_W-1:0] base;
  logic [7:0]        fetch_idx;
  logic [7:0]        load_idx;
  logic [2:0]        pix_cnt;
  logic [1:0]        fifo_count;
  logic [7:0]        fifo_head;
  logic              fifo_empty;
  logic              xfer;
  logic              load;
  logic              pop;
  logic              ur_set;
  logic              line_end;

  byte_fifo2 u_fifo (
    .clk    (clk),
    .nReset (nReset),
    .push   (xfer),
    .pop    (pop),
    .flush  (lineStart),
    .din    (fetchData),
    .count  (fifo_count),
    .head   (fifo_head)
  );

  // State register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state plus the combinational fetch/load strobes; lineStart always restarts.
  always_comb begin
    state_n    = state;
    fifo_empty = (fifo_count == 2'd0);
    fetchReq   = 1'b0;
    load       = 1'b0;
    line_end   = 1'b0;
    if (state != IDLE && !lineStart && fetch_idx < LB && fifo_count != 2'd2) begin
      fetchReq = 1'b1;
    end
    if (state == ACTIVE && pixEn) begin
      load     = (pix_cnt == 3'd0);
      line_end = (pix_cnt == 3'(PIX_PER_BYTE - 1)) && (load_idx == LB);
    end
    case (state)
      IDLE:    state_n = IDLE;
      PRIME:   if (fifo_count == 2'd2 || fetch_idx == LB) state_n = ACTIVE;
      ACTIVE:  if (line_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (lineStart) begin
      state_n = PRIME;
    end
  end

  assign xfer      = fetchReq && fetchAck;
  assign pop       = load && !fifo_empty;
  assign ur_set    = load && fifo_empty;
  assign shLoad    = load;
  assign shData    = pop ? fifo_head : 8'h00;
  assign active    = (state != IDLE);
  assign fetchAddr = (state == IDLE) ? '0 : base + ADDR_W'(fetch_idx);
  assign dbg_state = state;

  // Line base, fetch/load indices and the pixel-within-byte counter.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      base      <= '0;
      fetch_idx <= 8'd0;
      load_idx  <= 8'd0;
      pix_cnt   <= 3'd0;
    end else if (lineStart) begin
      base      <= lineBase;
      fetch_idx <= 8'd0;
      load_idx  <= 8'd0;
      pix_cnt   <= 3'd0;
    end else begin
      if (xfer) begin
        fetch_idx <= fetch_idx + 8'd1;
      end
      if (state == ACTIVE && pixEn) begin
        pix_cnt <= pix_cnt + 3'd1;
      end
      if (load) begin
        load_idx <= load_idx + 8'd1;
      end
    end
  end

  // End-of-line pulse (suppressed by a coincident restart) and sticky underrun flag.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      lineDone <= 1'b0;
      underrun <= 1'b0;
    end else begin
      lineDone <= line_end && !lineStart;
      if (ur_set) begin
        underrun <= 1'b1;
      end else if (clrErr) begin
        underrun <= 1'b0;
      end
    end
  end

`ifdef SEVGA_UNDERRUN_CNT_EN
  // Saturating underrun counter; a coincident clear and underrun leaves it at 1.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      underrunCnt <= 8'h00;
    end else if (ur_set) begin
      if (clrErr) begin
        underrunCnt <= 8'h01;
      end else if (underrunCnt != 8'hFF) begin
        underrunCnt <= underrunCnt + 8'h01;
      end
    end else if (clrErr) begin
      underrunCnt <= 8'h00;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_shift_ctrl.sv
// Bench for pixel_shift_ctrl (LINE_BYTES=4). Honours SEVGA_UNDERRUN_CNT_EN.
module tb_pixel_shift_ctrl;
  import sevga_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        nReset;
  logic        lineStart;
  logic [14:0] lineBase;
  logic        pixEn;
  logic        fetchReq;
  logic [14:0] fetchAddr;
  logic        fetchAck = 1'b0;
  logic [7:0]  fetchData = 8'h00;
  logic        shLoad;
  logic [7:0]  shData;
  logic        active;
  logic        lineDone;
  logic        underrun;
  logic        clrErr;
  shctl_state_t dbg_state;
`ifdef SEVGA_UNDERRUN_CNT_EN
  logic [7:0]  underrunCnt;
`endif

  always #5 clk = ~clk;

  pixel_shift_ctrl #(.LINE_BYTES(4), .ADDR_W(15)) dut (
    .clk        (clk),
    .nReset     (nReset),
    .lineStart  (lineStart),
    .lineBase   (lineBase),
    .pixEn      (pixEn),
    .fetchReq   (fetchReq),
    .fetchAddr  (fetchAddr),
    .fetchAck   (fetchAck),
    .fetchData  (fetchData),
    .shLoad     (shLoad),
    .shData     (shData),
    .active     (active),
    .lineDone   (lineDone),
    .underrun   (underrun),
`ifdef SEVGA_UNDERRUN_CNT_EN
    .underrunCnt(underrunCnt),
`endif
    .clrErr     (clrErr),
    .dbg_state  (dbg_state)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string name, input logic [7:0] exp);
`ifdef SEVGA_UNDERRUN_CNT_EN
    check(name, 32'(underrunCnt), 32'(exp));
`else
    if (exp == 8'hEE) $display("unreachable %s", name);
`endif
  endtask

  // ---------------- frame memory + fetch slave ----------------
  function automatic logic [7:0] mem_byte(input logic [14:0] a);
    case (a)
      15'h0100: return 8'hA5;
      15'h0101: return 8'h3C;
      15'h0102: return 8'hFF;
      15'h0103: return 8'h01;
      default:  return a[7:0] ^ 8'hC3 ^ {1'b0, a[14:8]};
    endcase
  endfunction

  bit ack_hold  = 1'b0;          // 1: ack held high; 0: ack one cycle after request
  int ack_limit = 32'h7fffffff;  // total transfers the slave will grant
  int given     = 0;

  // Slave decides ack after the bench has driven inputs for this cycle.
  always begin : resp
    logic a;
    bit   seen;
    bit   xfer_pend;
    @(negedge clk);
    #2;
    if (xfer_pend) given++;
    fetchData = mem_byte(fetchAddr);
    if (ack_hold) begin
      a = (given < ack_limit);
    end else begin
      a    = fetchReq && seen && (given < ack_limit);
      seen = fetchReq && !a;
    end
    fetchAck  = a;
    xfer_pend = fetchReq && a;
  end

  // ---------------- monitor / scoreboard capture ----------------
  int          clr_req = 0;
  int          clr_seen = 0;
  logic [14:0] xa_q[$];
  logic [7:0]  ld_q[$];
  int          lp_q[$];
  int          pix_i = 0;
  int          done_n = 0;
  int          occ = 0;
  int          viol = 0;

  always begin
    @(negedge clk);
    #3;
    if (clr_req != clr_seen) begin
      xa_q.delete(); ld_q.delete(); lp_q.delete();
      pix_i = 0; done_n = 0; occ = 0; viol = 0;
      clr_seen = clr_req;
    end
    if (nReset) begin
      if (lineDone) done_n++;
      if (lineStart) begin
        occ   = 0;
        pix_i = 0;
      end else begin
        if (fetchReq && occ >= 2) viol++;
        if (fetchReq && fetchAck) begin
          xa_q.push_back(fetchAddr);
          occ++;
        end
        if (shLoad) begin
          ld_q.push_back(shData);
          lp_q.push_back(pix_i);
          if (occ > 0) occ--;
        end
        if (occ > 2) viol++;
        if (pixEn && dbg_state == ACTIVE) pix_i++;
      end
    end else begin
      occ = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_line(input logic [14:0] b, input bit every);
    @(negedge clk);
    clr_req++;
    lineBase  = b;
    lineStart = 1'b1;
    pixEn     = 1'b0;
    @(negedge clk);
    lineStart = 1'b0;
    for (int c = 0; c < 600 && done_n == 0; c++) begin
      pixEn = every ? 1'b1 : c[0];
      @(negedge clk);
    end
    pixEn = 1'b0;
  endtask

  task automatic pix(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pixEn = 1'b1;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [14:0]      base;
    bit               hold;
    bit               every;
    logic [3:0][14:0] exp_addr;
    logic [3:0][7:0]  exp_ld;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] exp_q[$];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int   n0;
    logic found;

    vecs[0] = '{15'h0100, 1'b0, 1'b1, {15'h0103, 15'h0102, 15'h0101, 15'h0100}, {8'h01, 8'hFF, 8'h3C, 8'hA5}};
    vecs[1] = '{15'h0200, 1'b1, 1'b1, {15'h0203, 15'h0202, 15'h0201, 15'h0200}, {8'hC2, 8'hC3, 8'hC0, 8'hC1}};
    vecs[2] = '{15'h7FFF, 1'b0, 1'b1, {15'h0002, 15'h0001, 15'h0000, 15'h7FFF}, {8'hC1, 8'hC2, 8'hC3, 8'h43}};
    vecs[3] = '{15'h0010, 1'b1, 1'b0, {15'h0013, 15'h0012, 15'h0011, 15'h0010}, {8'hD0, 8'hD1, 8'hD2, 8'hD3}};

    nReset = 1'b0; lineStart = 1'b0; lineBase = '0; pixEn = 1'b0; clrErr = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #4;
    check("rst_fetchReq", 32'(fetchReq), 0);
    check("rst_fetchAddr", 32'(fetchAddr), 0);
    check("rst_shLoad", 32'(shLoad), 0);
    check("rst_shData", 32'(shData), 0);
    check("rst_active", 32'(active), 0);
    check("rst_lineDone", 32'(lineDone), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check_cnt("rst_cnt", 8'h00);
    @(negedge clk);
    nReset = 1'b1;

    // pixEn in IDLE is ignored
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pixEn = 1'b1;
      #4;
      check("idle_shLoad", 32'(shLoad), 0);
    end
    pixEn = 1'b0;

    // Table-driven full lines
    foreach (vecs[v]) begin
      ack_hold = vecs[v].hold;
      run_line(vecs[v].base, vecs[v].every);
      for (int i = 0; i < 4; i++) exp_q.push_back(vecs[v].exp_ld[i]);
      check($sformatf("v%0d_nxfer", v), 32'(xa_q.size()), 4);
      check($sformatf("v%0d_nload", v), 32'(ld_q.size()), 4);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("v%0d_addr%0d", v, i), 32'(xa_q[i]), 32'(vecs[v].exp_addr[i]));
        check($sformatf("v%0d_data%0d", v, i), 32'(ld_q[i]), 32'(exp_q.pop_front()));
        check($sformatf("v%0d_pix%0d", v, i), 32'(lp_q[i]), 32'(i * 8));
      end
      check($sformatf("v%0d_done", v), 32'(done_n), 1);
      check($sformatf("v%0d_underrun", v), 32'(underrun), 0);
      check($sformatf("v%0d_occupancy", v), 32'(viol), 0);
    end
    ack_hold = 1'b0;

    // Restart at pixel 10
    @(negedge clk);
    clr_req++;
    lineBase = 15'h0300; lineStart = 1'b1;
    @(negedge clk);
    lineStart = 1'b0;
    for (int c = 0; c < 200 && pix_i < 10; c++) begin
      pixEn = 1'b1;
      @(negedge clk);
    end
    check("restart_pix10", 32'(pix_i), 10);
    pixEn = 1'b0; clr_req++; lineBase = 15'h0400; lineStart = 1'b1;
    #4;
    check("restart_req_drop", 32'(fetchReq), 0);
    @(negedge clk);
    lineStart = 1'b0;
    #4;
    check("restart_prime", 32'(dbg_state), 32'(PRIME));
    for (int c = 0; c < 600 && done_n == 0; c++) begin
      pixEn = 1'b1;
      @(negedge clk);
    end
    pixEn = 1'b0;
    repeat (5) @(negedge clk);
    exp_q.push_back(8'hC7); exp_q.push_back(8'hC6); exp_q.push_back(8'hC5); exp_q.push_back(8'hC4);
    check("restart_addr0", 32'(xa_q[0]), 32'h0400);
    check("restart_nload", 32'(ld_q.size()), 4);
    for (int i = 0; i < 4; i++) check($sformatf("restart_data%0d", i), 32'(ld_q[i]), 32'(exp_q.pop_front()));
    check("restart_done", 32'(done_n), 1);

    // Underrun: only two bytes granted
    ack_limit = given + 2;
    @(negedge clk);
    clr_req++;
    lineBase = 15'h0500; lineStart = 1'b1;
    @(negedge clk);
    lineStart = 1'b0;
    for (int c = 0; c < 50 && dbg_state != ACTIVE; c++) @(negedge clk);
    check("stall_active", 32'(dbg_state), 32'(ACTIVE));
    pix(16);
    @(negedge clk);
    pixEn = 1'b1; clrErr = 1'b1;
    #4;
    check("stall_load2", 32'(shLoad), 1);
    check("stall_data2", 32'(shData), 0);
    @(negedge clk);
    clrErr = 1'b0;
    #4;
    check("setwins_underrun", 32'(underrun), 1);
    check_cnt("setwins_cnt", 8'h01);
    pix(14);
    @(negedge clk);
    pixEn = 1'b0;
    #4;
    check("stall_lineDone", 32'(lineDone), 1);
    check("stall_nload", 32'(ld_q.size()), 4);
    check("stall_data0", 32'(ld_q[0]), 32'hC6);
    check("stall_data1", 32'(ld_q[1]), 32'hC7);
    check("stall_data3", 32'(ld_q[3]), 0);
    check("stall_underrun", 32'(underrun), 1);
    check_cnt("stall_cnt", 8'h02);
    @(negedge clk);
    clrErr = 1'b1;
    @(negedge clk);
    clrErr = 1'b0;
    #4;
    check("clr_underrun", 32'(underrun), 0);
    check_cnt("clr_cnt", 8'h00);

`ifdef SEVGA_UNDERRUN_CNT_EN
    // 300 underruns saturate the counter
    for (int l = 0; l < 150; l++) begin
      ack_limit = given + 2;
      run_line(15'h0600, 1'b1);
    end
    #4;
    check_cnt("sat_cnt", 8'hFF);
    check("sat_underrun", 32'(underrun), 1);
    @(negedge clk);
    clrErr = 1'b1;
    @(negedge clk);
    clrErr = 1'b0;
`endif
    ack_limit = 32'h7fffffff;

    // Reset mid-ACTIVE with a pending request
    @(negedge clk);
    lineBase = 15'h0700; lineStart = 1'b1;
    @(negedge clk);
    lineStart = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      pixEn = 1'b1;
      #4;
      found = (dbg_state == ACTIVE) && fetchReq;
    end
    check("rst_mid_found", 32'(found), 1);
    nReset = 1'b0;
    #1;
    check("rst_mid_req", 32'(fetchReq), 0);
    check("rst_mid_shLoad", 32'(shLoad), 0);
    check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    #4;
    check("rst_mid_addr", 32'(fetchAddr), 0);
    check("rst_mid_active", 32'(active), 0);
    check("rst_mid_lineDone", 32'(lineDone), 0);
    check("rst_mid_underrun", 32'(underrun), 0);
    check("rst_mid_shData", 32'(shData), 0);
    @(negedge clk);
    nReset = 1'b1;
    n0 = ld_q.size();
    repeat (20) @(negedge clk);
    pixEn = 1'b0;
    #4;
    check("rst_mid_noload", 32'(ld_q.size()), 32'(n0));
    check("rst_mid_idle", 32'(dbg_state), 32'(IDLE));
    check("rst_mid_req_idle", 32'(fetchReq), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
